mdu_iterative: RTL and testbench

Iterative RV32M multiply/divide unit for the execute stage, parametrised in operand width. It decodes `funct3_i` into one of the eight M-extension operations and computes the result with a shared shift-add / restoring-divide datapath at one bit per cycle. A valid/ready handshake on the input side and a one-cycle result strobe let the pipeline stall around it. A flush input aborts an in-flight operation.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_iterative.sv | 150 +++++++++++++++
 tb/tb_mdu_iterative.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Purpose: shared types for the iterative RV32M multiply/divide unit.
// Contents: funct3 operation encodings, FSM state encodings, op-class helper.
// Used by: mdu_iterative.
package mdu_pkg;

   // funct3 encodings of the M extension
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   // All divide/remainder ops have funct3[2] set
   function automatic logic is_div(input mdu_op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Purpose: iterative RV32M multiply/divide, one bit per cycle on a shared shift-add / restoring-divide datapath.
// Latency: accept in cycle 0, valid_o in cycle XLEN+2 (normal ops) or cycle 1 (divide-by-zero / signed overflow).
// Backpressure: ready_o high only in IDLE; valid_i elsewhere is ignored; flush_i aborts CALC/FIX with no result.
// Ports: clk_i, rst_i (sync, active-high); valid_i/ready_o request handshake with funct3_i, rs1_i, rs2_i;
//        flush_i abort; busy_o (CALC/FIX); valid_o one-cycle result strobe; result_o held until next completion.
module mdu_iterative
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e        state;
   mdu_op_e           op_q;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;      // multiply: {partial high, multiplier}; divide: {remainder, quotient}
   logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
   logic              neg_q;    // negate product / quotient
   logic              neg_r;    // negate remainder (sign of rs1)

   // ---------------- accept-time decode ----------------
   mdu_op_e         op_in;
   logic            s1, s2;
   logic [XLEN-1:0] mag1, mag2;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] special_res;

   always_comb begin
      op_in = mdu_op_e'(funct3_i);
      s1    = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && rs1_i[XLEN-1];
      s2    = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && rs2_i[XLEN-1];
      mag1  = s1 ? -rs1_i : rs1_i;
      mag2  = s2 ? -rs2_i : rs2_i;
      div_zero = is_div(op_in) && (rs2_i == '0);
      div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (rs1_i == MOST_NEG) && (rs2_i == '1);
      special_res = '0;
      if (div_zero)
         special_res = op_in[1] ? rs1_i : '1;       // REM/REMU: rs1, DIV/DIVU: all ones
      else if (div_ovf)
         special_res = op_in[1] ? '0 : rs1_i;
   end

   // ---------------- shared adder / subtractor ----------------
   // Divide: trial-subtract the divisor from {remainder, next dividend bit};
   // carry-out set means no borrow, i.e. the quotient bit is 1.
   logic              div_mode;
   logic [XLEN:0]     add_a, add_b;
   logic [XLEN+1:0]   add_s;
   logic [XLEN:0]     mul_top;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] acc_next;

   always_comb begin
      div_mode = is_div(op_q);
      add_a    = div_mode ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
      add_b    = div_mode ? ~{1'b0, opnd} : {1'b0, opnd};
      add_s    = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, div_mode};
      mul_top  = acc[0] ? add_s[XLEN:0] : {1'b0, acc[2*XLEN-1:XLEN]};
      div_rem  = add_s[XLEN+1] ? add_s[XLEN-1:0] : acc[2*XLEN-2:XLEN-1];
      if (div_mode)
         acc_next = {div_rem, acc[XLEN-2:0], add_s[XLEN+1]};
      else
         acc_next = {mul_top, acc[XLEN-1:1]};
   end

   // ---------------- sign fix-up ----------------
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fix_res;

   always_comb begin
      prod = neg_q ? -acc : acc;
      quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (div_mode)
         fix_res = op_q[1] ? rem : quo;
      else
         fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   // ---------------- FSM and state ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         op_q     <= OP_MUL;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (valid_i && !flush_i) begin
                  op_q  <= op_in;
                  neg_q <= s1 ^ s2;
                  neg_r <= s1;
                  if (div_zero || div_ovf) begin
                     result_o <= special_res;
                     state    <= ST_DONE;
                  end else begin
                     cnt   <= CW'(XLEN);
                     acc   <= {{XLEN{1'b0}}, is_div(op_in) ? mag1 : mag2};
                     opnd  <= is_div(op_in) ? mag2 : mag1;
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (flush_i) begin
                  state <= ST_IDLE;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt - CW'(1);
                  if (cnt == CW'(1))
                     state <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (flush_i) begin
                  state <= ST_IDLE;
               end else begin
                  result_o <= fix_res;
                  state    <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;   // DONE returns to IDLE unconditionally
         endcase
      end
   end

   assign ready_o = (state == ST_IDLE);
   assign busy_o  = (state == ST_CALC) || (state == ST_FIX);
   assign valid_o = (state == ST_DONE);

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic        flush_i;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] result_o;

   int checks   = 0;
   int failures = 0;

   mdu_iterative #(.XLEN(32)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .funct3_i (funct3_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .flush_i  (flush_i),
      .busy_o   (busy_o),
      .valid_o  (valid_o),
      .result_o (result_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Wait (bounded) for ready, issue one request, then watch valid_o for 45 cycles.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output int nvld);
      int w;
      w = 0;
      @(negedge clk_i);
      while (!ready_o && w < 50) begin
         @(negedge clk_i);
         w++;
      end
      chk("ready_wait", {31'd0, ready_o}, 32'd1);
      funct3_i = f; rs1_i = a; rs2_i = b; valid_i = 1'b1;
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      lat = -1; nvld = 0; res = 'x;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk_i);
         if (valid_o) begin
            nvld++;
            if (lat < 0) begin
               lat = c;
               res = result_o;
            end
         end
      end
   endtask

   vec_t vecs[$];

   initial begin
      int          lat, nvld, c0, c1, w;
      logic [31:0] res;

      vecs.push_back('{"mul_7_m3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34});
      vecs.push_back('{"mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34});
      vecs.push_back('{"mulh_m1_m1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34});
      vecs.push_back('{"mulhu_max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
      vecs.push_back('{"mulhsu_max",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
      vecs.push_back('{"div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
      vecs.push_back('{"rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
      vecs.push_back('{"div_7_m2",      3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34});
      vecs.push_back('{"rem_7_m2",      3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 34});
      vecs.push_back('{"divu_100_7",    3'b101, 32'd100,      32'd7,        32'h0000000E, 34});
      vecs.push_back('{"remu_100_7",    3'b111, 32'd100,      32'd7,        32'h00000002, 34});
      vecs.push_back('{"remu_big",      3'b111, 32'h12345678, 32'h00001000, 32'h00000678, 34});
      vecs.push_back('{"div_5_0",       3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
      vecs.push_back('{"rem_5_0",       3'b110, 32'd5,        32'd0,        32'h00000005, 1});
      vecs.push_back('{"divu_7_0",      3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 1});
      vecs.push_back('{"div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
      vecs.push_back('{"rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
      vecs.push_back('{"mul_3_4",       3'b000, 32'd3,        32'd4,        32'h0000000C, 34});

      rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
      funct3_i = 3'b000; rs1_i = '0; rs2_i = '0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_ready",  {31'd0, ready_o}, 32'd1);
      chk("rst_busy",   {31'd0, busy_o},  32'd0);
      chk("rst_valid",  {31'd0, valid_o}, 32'd0);
      chk("rst_result", result_o,         32'd0);

      // Directed vector table
      foreach (vecs[i]) begin
         do_op(vecs[i].f, vecs[i].a, vecs[i].b, lat, res, nvld);
         chk({vecs[i].name, "_result"}, res, vecs[i].exp);
         chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
         chk({vecs[i].name, "_vld_count"}, 32'(nvld), 32'd1);
      end

      // Flush in cycle 10 of a DIV
      do_op(3'b101, 32'd100, 32'd7, lat, res, nvld);
      chk("pre_flush_result", res, 32'h0000000E);
      @(negedge clk_i);
      funct3_i = 3'b100; rs1_i = 32'd1000; rs2_i = 32'd3; valid_i = 1'b1;
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      repeat (9) @(posedge clk_i);
      #1 flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush_busy_c10", {31'd0, busy_o}, 32'd1);
      @(posedge clk_i);
      #1 flush_i = 1'b0;
      @(negedge clk_i);
      chk("flush_ready_c11", {31'd0, ready_o}, 32'd1);
      chk("flush_busy_c11",  {31'd0, busy_o},  32'd0);
      nvld = 0;
      for (int c = 0; c < 40; c++) begin
         if (valid_o) nvld++;
         @(negedge clk_i);
      end
      chk("flush_no_vld", 32'(nvld), 32'd0);
      chk("flush_result_kept", result_o, 32'h0000000E);
      do_op(3'b000, 32'd3, 32'd4, lat, res, nvld);
      chk("post_flush_mul", res, 32'h0000000C);
      chk("post_flush_lat", 32'(lat), 32'd34);

      // Reset in cycle 20 of a DIV
      @(negedge clk_i);
      funct3_i = 3'b100; rs1_i = 32'd1000; rs2_i = 32'd3; valid_i = 1'b1;
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      repeat (19) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_mid_ready",  {31'd0, ready_o}, 32'd1);
      chk("rst_mid_busy",   {31'd0, busy_o},  32'd0);
      chk("rst_mid_result", result_o,         32'd0);
      nvld = 0;
      for (int c = 0; c < 40; c++) begin
         if (valid_o) nvld++;
         @(negedge clk_i);
      end
      chk("rst_mid_no_vld", 32'(nvld), 32'd0);
      do_op(3'b000, 32'd3, 32'd4, lat, res, nvld);
      chk("post_rst_mul", res, 32'h0000000C);

      // valid_i held with changing operands during CALC: only first request executes
      @(negedge clk_i);
      funct3_i = 3'b000; rs1_i = 32'd6; rs2_i = 32'd9; valid_i = 1'b1;
      @(posedge clk_i);
      lat = -1; nvld = 0; res = 'x;
      for (int c = 1; c <= 40; c++) begin
         #1;
         if (c < 34) begin
            funct3_i = 3'($urandom_range(0, 7));
            rs1_i = $urandom; rs2_i = $urandom;
         end else begin
            valid_i = 1'b0;
         end
         @(negedge clk_i);
         if (valid_o) begin
            nvld++;
            if (lat < 0) begin lat = c; res = result_o; end
         end
         @(posedge clk_i);
      end
      chk("gate_result", res, 32'd54);
      chk("gate_lat", 32'(lat), 32'd34);
      chk("gate_vld_count", 32'(nvld), 32'd1);

      // Back-to-back issue interval: normal op, then special case
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         funct3_i = (k == 0) ? 3'b000 : 3'b100;
         rs1_i = 32'd5; rs2_i = (k == 0) ? 32'd4 : 32'd0;
         valid_i = 1'b1;
         c0 = -1; c1 = -1; w = 0;
         while (c1 < 0 && w < 100) begin
            if (ready_o) begin
               if (c0 < 0) c0 = w;
               else c1 = w;
            end
            @(negedge clk_i);
            w++;
         end
         valid_i = 1'b0;
         chk(k == 0 ? "b2b_interval_normal" : "b2b_interval_special", 32'(c1 - c0), (k == 0) ? 32'd35 : 32'd2);
         repeat (40) @(negedge clk_i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
